double_buffer_core: RTL and testbench
=====================================

DOUBLE_BUFFER_CORE -- requirements
Module: double_buffer_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, words per bank; power of two, 2..1024.
REQ-003 SHALL have parameter DIMS, default 3, address-generator loop dimensions; 1..6.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports clk_en  input  1  global enable; flush  input  1  synchronous return to reset state.
REQ-007 SHALL have ports data_in  input  DATA_WIDTH  write data; wen_in  input  1  write strobe.
REQ-008 SHALL have ports ren_in  input  1  read strobe; data_out  output  DATA_WIDTH  read data; valid_out  output  1  data_out qualifier.
REQ-009 SHALL have ports depth  input  16  words per fill; iter_cnt  input  32  reads per drain; starting_addr  input  16  read base address.
REQ-010 SHALL have ports stride  input  DIMS*16  per-dimension strides, dim 0 at LSBs; range  input  DIMS*32  per-dimension trip counts, dim 0 at LSBs.
REQ-011 SHALL have ports switch_db  input  1  manual bank-swap request; full  output  1  write bank full; empty  output  1  read bank has no pending reads.

Function
REQ-012 SHALL hold two banks of DEPTH words; wr_bank selects the bank being filled, the other bank is the read bank.
REQ-013 SHALL clamp the effective depth to DEPTH when depth is 0 or exceeds DEPTH.
REQ-014 SHALL, on clk_en & wen_in & wr_cnt<depth, write data_in to wr_bank[wr_cnt] and increment wr_cnt; when wr_cnt==depth, SHALL silently drop wen_in.
REQ-015 SHALL drive full = (wr_cnt==depth).
REQ-016 SHALL hold rd_valid_bank, set on each swap and cleared by reset/flush; SHALL ignore ren_in while rd_valid_bank==0 or rd_cnt==iter_cnt.
REQ-017 SHALL, on an accepted read (clk_en & ren_in & rd_valid_bank & rd_cnt<iter_cnt), compute address = starting_addr + sum over d of idx[d]*stride[d] in 32 bits, truncated to log2(DEPTH) bits.
REQ-018 SHALL, after each accepted read, increment idx[0]; on idx[d]==range[d]-1, SHALL clear idx[d] and carry into idx[d+1]; the top dimension wraps to 0; range[d] of 0 is treated as 1.
REQ-019 SHALL register read data: data_out and valid_out=1 exactly one cycle after an accepted read; otherwise valid_out=0 and data_out holds its last value.
REQ-020 SHALL drive empty = ~rd_valid_bank | (rd_cnt==iter_cnt); iter_cnt==0 SHALL make the read bank empty immediately.
REQ-021 SHALL define swap_ok = full & empty, evaluated on registered state.
REQ-022 SHALL, on a swap, toggle wr_bank, clear wr_cnt, rd_cnt and all idx, and set rd_valid_bank; a read accepted in the cycle before the swap still produces its valid_out.
REQ-023 SHALL ignore clk_en==0 cycles entirely, except for flush and reset.
REQ-024 SHALL give flush priority over all operations; it returns every register to its reset value at the next edge, independent of clk_en.

Reset
REQ-025 SHALL asynchronously reset wr_bank=0, wr_cnt=0, rd_cnt=0, idx=0, rd_valid_bank=0, data_out=0, valid_out=0; hence full=0 and empty=1.
REQ-026 SHALL NOT reset memory contents; reset mid-drain SHALL abort the in-flight read and deassert valid_out immediately.

Configuration
REQ-027 SHALL honour macro DB_AUTO_SWITCH_EN: when defined, a swap occurs on any clk_en cycle with swap_ok and switch_db is ignored.
REQ-028 When DB_AUTO_SWITCH_EN is undefined, a swap SHALL occur only on clk_en & switch_db & swap_ok; switch_db without swap_ok SHALL be ignored and not remembered.

Verification
REQ-029 Auto mode, DEPTH=64, depth=9, write 0..8 -> full=1 at cycle 9, swap at cycle 10, then full=0, empty=0.
REQ-030 After REQ-029, stride={9,3,1}, range={1,3,3}, iter_cnt=9, ren_in held high -> data_out 0,1,2,3,4,5,6,7,8, valid_out each one cycle after its read, then empty=1.
REQ-031 Same setup with stride={9,1,3} -> data_out 0,3,6,1,4,7,2,5,8.
REQ-032 A 10th write with depth=9 -> dropped; wr_cnt stays 9 and bank contents are unchanged.
REQ-033 Macro undefined, full and empty both 1, switch_db=0 for 20 cycles -> no swap; one switch_db pulse -> swap on that edge.
REQ-034 Reset asserted during read 4 of 9 -> valid_out=0 immediately; empty=1, full=0; the next fill starts at wr_bank=0.

Source files
------------

// File: rtl/double_buffer_core.sv
// Ping-pong buffer: one bank fills linearly while the other drains through a
// multi-dimensional strided address generator. Build option: DB_AUTO_SWITCH_EN.
module double_buffer_core #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int DIMS       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen_in,
    input  logic                  ren_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic [15:0]           depth,
    input  logic [31:0]           iter_cnt,
    input  logic [15:0]           starting_addr,
    input  logic [DIMS*16-1:0]    stride,
    input  logic [DIMS*32-1:0]    range,
    input  logic                  switch_db,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0]  mem [2*DEPTH];

    logic                   wr_bank;
    logic [CW-1:0]          wr_cnt;
    logic [31:0]            rd_cnt;
    logic [DIMS-1:0][31:0]  idx;
    logic                   rd_valid_bank;

    logic [CW-1:0]          eff_depth;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   swap_ok;
    logic                   swap;
    logic [31:0]            addr_sum;
    logic [AW-1:0]          rd_addr;
    logic                   addr_unused;
    logic [DIMS-1:0][31:0]  rng_last;
    logic [DIMS-1:0][31:0]  idx_next;
    logic                   carry;

    always_comb begin
        if (depth == 16'd0 || depth > 16'(DEPTH))
            eff_depth = CW'(DEPTH);
        else
            eff_depth = depth[CW-1:0];
    end

    assign full    = (wr_cnt == eff_depth);
    assign empty   = ~rd_valid_bank | (rd_cnt == iter_cnt);
    assign swap_ok = full & empty;

    assign wr_acc = clk_en & wen_in & (wr_cnt < eff_depth);
    assign rd_acc = clk_en & ren_in & rd_valid_bank & (rd_cnt < iter_cnt);

`ifdef DB_AUTO_SWITCH_EN
    logic switch_unused;
    assign switch_unused = switch_db;
    assign swap          = clk_en & swap_ok;
`else
    assign swap = clk_en & switch_db & swap_ok;
`endif

    // Full 32-bit address sum, then keep only the bank-local bits.
    always_comb begin
        addr_sum = {16'd0, starting_addr};
        for (int d = 0; d < DIMS; d++) begin
            addr_sum = addr_sum + idx[d] * {16'd0, stride[d*16 +: 16]};
        end
    end

    assign rd_addr     = addr_sum[AW-1:0];
    assign addr_unused = ^addr_sum[31:AW];

    always_comb begin
        for (int d = 0; d < DIMS; d++) begin
            if (range[d*32 +: 32] == 32'd0)
                rng_last[d] = 32'd0;
            else
                rng_last[d] = range[d*32 +: 32] - 32'd1;
        end
    end

    // Odometer step; a carry out of the top dimension is discarded so it wraps.
    always_comb begin
        idx_next = idx;
        carry    = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (carry) begin
                if (idx[d] == rng_last[d]) begin
                    idx_next[d] = 32'd0;
                end else begin
                    idx_next[d] = idx[d] + 32'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush && !reset)
            mem[{wr_bank, wr_cnt[AW-1:0]}] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= 32'd0;
            idx           <= '0;
            rd_valid_bank <= 1'b0;
            data_out      <= '0;
            valid_out     <= 1'b0;
        end else if (flush) begin
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= 32'd0;
            idx           <= '0;
            rd_valid_bank <= 1'b0;
            data_out      <= '0;
            valid_out     <= 1'b0;
        end else begin
            // valid_out is a single-cycle pulse; data_out holds between reads.
            valid_out <= rd_acc;
            if (rd_acc)
                data_out <= mem[{~wr_bank, rd_addr}];

            if (swap) begin
                wr_bank       <= ~wr_bank;
                wr_cnt        <= '0;
                rd_cnt        <= 32'd0;
                idx           <= '0;
                rd_valid_bank <= 1'b1;
            end else begin
                if (wr_acc)
                    wr_cnt <= wr_cnt + CW'(1);
                if (rd_acc) begin
                    rd_cnt <= rd_cnt + 32'd1;
                    idx    <= idx_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_double_buffer_core.sv
// Scoreboard bench for double_buffer_core: directed scenarios then random traffic,
// checked against an index-decomposition reference model.
module tb_double_buffer_core;

    localparam int DW   = 16;
    localparam int DEP  = 64;
    localparam int DIMS = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                clk_en = 1'b0;
    logic                flush = 1'b0;
    logic [DW-1:0]       data_in = '0;
    logic                wen_in = 1'b0;
    logic                ren_in = 1'b0;
    logic [DW-1:0]       data_out;
    logic                valid_out;
    logic [15:0]         depth = '0;
    logic [31:0]         iter_cnt = '0;
    logic [15:0]         starting_addr = '0;
    logic [DIMS*16-1:0]  stride = '0;
    logic [DIMS*32-1:0]  range = '0;
    logic                switch_db = 1'b0;
    logic                full;
    logic                empty;

    double_buffer_core #(.DATA_WIDTH(DW), .DEPTH(DEP), .DIMS(DIMS)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
        .data_in(data_in), .wen_in(wen_in), .ren_in(ren_in),
        .data_out(data_out), .valid_out(valid_out),
        .depth(depth), .iter_cnt(iter_cnt), .starting_addr(starting_addr),
        .stride(stride), .range(range), .switch_db(switch_db),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] data; int unsigned due; } exp_t;
    exp_t sb[$];

    // reference model state
    int unsigned bank [2][DEP];
    int unsigned m_wr_bank, m_wr_cnt, m_rd_n;
    bit          m_rd_valid;

    int unsigned c_depth, c_iter, c_start;
    int unsigned c_stride [DIMS];
    int unsigned c_range  [DIMS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned eff_depth();
        return (c_depth == 0 || c_depth > DEP) ? DEP : c_depth;
    endfunction

    // Read n decomposed into mixed-radix digits, one per dimension.
    function automatic int unsigned read_addr(input int unsigned n);
        int unsigned sum = c_start;
        int unsigned div = 1;
        for (int d = 0; d < DIMS; d++) begin
            int unsigned r = (c_range[d] == 0) ? 1 : c_range[d];
            sum += ((n / div) % r) * c_stride[d];
            div *= r;
        end
        return sum % DEP;
    endfunction

    function automatic bit m_full();
        return m_wr_cnt == eff_depth();
    endfunction

    function automatic bit m_empty();
        return !m_rd_valid || m_rd_n == c_iter;
    endfunction

    task automatic apply_cfg();
        depth         = c_depth[15:0];
        iter_cnt      = c_iter;
        starting_addr = c_start[15:0];
        for (int d = 0; d < DIMS; d++) begin
            stride[d*16 +: 16] = 16'(c_stride[d]);
            range[d*32 +: 32]  = c_range[d];
        end
    endtask

    task automatic model_clear();
        m_wr_bank = 0; m_wr_cnt = 0; m_rd_n = 0; m_rd_valid = 0;
        sb.delete();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_full"}, {31'd0, full}, {31'd0, m_full()});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, m_empty()});
    endtask

    task automatic cycle(input bit ce, input bit wen, input logic [DW-1:0] din,
                         input bit ren, input bit sw, output bit swapped);
        bit wr_acc, rd_acc;
        @(negedge clk);
        clk_en = ce; wen_in = wen; data_in = din; ren_in = ren; switch_db = sw;
        wr_acc  = ce && wen && (m_wr_cnt < eff_depth());
        rd_acc  = ce && ren && m_rd_valid && (m_rd_n < c_iter);
        swapped = ce && sw && m_full() && m_empty();
        if (rd_acc)
            sb.push_back('{DW'(bank[1-m_wr_bank][read_addr(m_rd_n)]), cyc + 1});
        @(posedge clk);
        if (wr_acc) begin
            bank[m_wr_bank][m_wr_cnt] = din;
            m_wr_cnt++;
        end
        if (rd_acc) m_rd_n++;
        if (swapped) begin
            m_wr_bank ^= 1; m_wr_cnt = 0; m_rd_n = 0; m_rd_valid = 1;
        end
        #1 check_flags("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clk_en = 0; wen_in = 0; ren_in = 0; switch_db = 0;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, 0, s);
    endtask

    // Monitor: each scoreboard entry must appear exactly on its due cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("rd_valid", {31'd0, valid_out}, 32'd1);
                check("rd_data", {16'd0, data_out}, {16'd0, e.data});
            end else begin
                check("no_spurious_valid", {31'd0, valid_out}, 32'd0);
            end
        end
    end

    initial begin
        bit s;
        do_reset();
        #1;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {16'd0, data_out}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);

        // Fill 0..8 into a 9-deep bank, then a dropped 10th write.
        c_depth = 9; c_iter = 9; c_start = 0;
        c_stride[0] = 1; c_stride[1] = 3; c_stride[2] = 9;
        c_range[0]  = 3; c_range[1]  = 3; c_range[2]  = 1;
        apply_cfg();
        for (int i = 0; i < 9; i++) cycle(1, 1, DW'(i), 0, 0, s);
        check("full_after_9", {31'd0, full}, 32'd1);
        cycle(1, 1, 16'h0099, 0, 0, s);
        check("full_after_drop", {31'd0, full}, 32'd1);

        // full & empty but no switch_db: must not swap.
        idle(20);
        check("no_swap_empty", {31'd0, empty}, 32'd1);
        cycle(1, 0, '0, 0, 1, s);
        check("swap_full", {31'd0, full}, 32'd0);
        check("swap_empty", {31'd0, empty}, 32'd0);

        // Linear drain while refilling the other bank with 0..8.
        for (int i = 0; i < 9; i++) cycle(1, 1, DW'(i), 1, 0, s);
        idle(1);
        check("drain1_empty", {31'd0, empty}, 32'd1);

        // Transposed drain; refill with 100..108.
        cycle(1, 0, '0, 0, 1, s);
        c_stride[0] = 3; c_stride[1] = 1;
        apply_cfg();
        for (int i = 0; i < 9; i++) cycle(1, 1, DW'(100 + i), 1, 0, s);
        idle(1);

        // Reset during the 4th of 9 reads.
        cycle(1, 0, '0, 0, 1, s);
        c_stride[0] = 1; c_stride[1] = 3;
        apply_cfg();
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1, 0, s);
        check("valid_before_reset", {31'd0, valid_out}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_full", {31'd0, full}, 32'd0);
        do_reset();

        // Partial refill exposes which bank was written after reset.
        c_depth = 4;
        apply_cfg();
        for (int i = 0; i < 4; i++) cycle(1, 1, DW'(200 + i), 0, 0, s);
        cycle(1, 0, '0, 0, 1, s);
        for (int i = 0; i < 9; i++) cycle(1, 0, '0, 1, 0, s);
        idle(1);

        // Flush with clk_en low still clears everything.
        c_depth = 9;
        apply_cfg();
        for (int i = 0; i < 3; i++) cycle(1, 1, DW'(i), 0, 0, s);
        @(negedge clk);
        flush = 1'b1; clk_en = 1'b0; wen_in = 1'b1; ren_in = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        check("flush_full", {31'd0, full}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_valid", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        flush = 1'b0; wen_in = 1'b0; ren_in = 1'b0;

        // Define every word of both banks (depth 0 clamps to DEP).
        c_depth = 0; c_iter = 0;
        apply_cfg();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEP; i++) cycle(1, 1, DW'($urandom), 0, 0, s);
            check("clamp_full", {31'd0, full}, 32'd1);
            cycle(1, 0, '0, 0, 1, s);
        end

        // Random traffic; read/fill configuration changes only right after a swap.
        for (int k = 0; k < 4000; k++) begin
            bit ce, wen, ren, sw;
            ce  = ($urandom_range(0, 9) < 8);
            wen = ($urandom_range(0, 9) < 7);
            ren = ($urandom_range(0, 9) < 7);
            sw  = ($urandom_range(0, 9) < 2);
            cycle(ce, wen, DW'($urandom), ren, sw, s);
            if (s && $urandom_range(0, 1) == 1) begin
                c_depth = $urandom_range(0, 70);
                c_iter  = $urandom_range(0, 20);
                c_start = $urandom_range(0, 65535);
                for (int d = 0; d < DIMS; d++) begin
                    c_stride[d] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                                             : $urandom_range(0, 9);
                    c_range[d]  = $urandom_range(0, 4);
                end
                apply_cfg();
            end
        end

        idle(3);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
